// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard scan-code front-end.
// Record layout is {ext, brk, code}; flags are the top two record bits.
package kbd_pkg;

  localparam logic [7:0] KBD_E0 = 8'hE0;
  localparam logic [7:0] KBD_F0 = 8'hF0;

  localparam int FLG_EXT = 1;
  localparam int FLG_BRK = 0;
  localparam int ERR_OVF = 1;
  localparam int ERR_FRM = 0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_NORMAL,
    DEC_GOT_E0,
    DEC_GOT_F0,
    DEC_GOT_E0F0
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } rec_t;

  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/kbd_ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect,
// start/data/parity/stop FSM and mid-frame stall timeout.
module kbd_ps2_rx
  import kbd_pkg::*;
#(
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbd_clk,
  input  logic       kbd_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic fall, bit_in;

  rx_state_t   state, nstate;
  logic [7:0]  shreg;
  logic [2:0]  bcnt;
  logic        par;
  logic [TW-1:0] tcnt;
  logic        tmo;
  logic        bv_d, fe_d;

  // Idle level is high, so synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      fall   <= 1'b0;
      bit_in <= 1'b1;
    end else begin
      clk_s1 <= kbd_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= kbd_data;
      dat_s2 <= dat_s1;
      fall   <= clk_s3 & ~clk_s2;
      bit_in <= dat_s2;
    end
  end

  assign tmo = (state != RX_IDLE) && (tcnt == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (tmo) begin
      nstate = RX_IDLE;
    end else if (fall) begin
      case (state)
        RX_IDLE:   if (!bit_in) nstate = RX_DATA;
        RX_DATA:   if (bcnt == 3'd7) nstate = RX_PARITY;
        RX_PARITY: nstate = RX_STOP;
        RX_STOP:   nstate = RX_IDLE;
        default:   nstate = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    bv_d = 1'b0;
    fe_d = 1'b0;
    if (tmo) begin
      fe_d = 1'b1;
    end else if (fall && state == RX_STOP) begin
      if (bit_in && odd_ok(shreg, par)) bv_d = 1'b1;
      else                              fe_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg      <= '0;
      bcnt       <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= bv_d;
      frame_err  <= fe_d;
      if (state == RX_IDLE || fall || tmo) tcnt <= '0;
      else                                 tcnt <= tcnt + 1'b1;
      if (fall && !tmo) begin
        case (state)
          RX_IDLE:   bcnt <= '0;
          RX_DATA: begin
            shreg <= {bit_in, shreg[7:1]};
            bcnt  <= bcnt + 1'b1;
          end
          RX_PARITY: par <= bit_in;
          default:   ;
        endcase
      end
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/kbd_scanq.sv
// PS/2 keyboard front-end: receiver, E0/F0 prefix decoder,
// FWFT record FIFO and sticky error status for the PicoBlaze port.
module kbd_scanq
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BREAK_MODE = 0,
  parameter int TIMEOUT    = 100000,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          kbd_clk,
  input  logic          kbd_data,
  input  logic          kbd2pico_rden,
  output logic [CW-1:0] kbd2pico_count,
  output logic [7:0]    kbd2pico_data,
  output logic [1:0]    kbd2pico_flags,
  output logic [1:0]    kbd_err,
  input  logic          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  kbd_ps2_rx #(
    .TIMEOUT(TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .kbd_clk   (kbd_clk),
    .kbd_data  (kbd_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  dec_state_t dstate, dnext;
  logic is_e0, is_f0;
  logic emit, ext, brk;
  logic rec_v;
  rec_t rec_q;

  assign is_e0 = (rx_byte == KBD_E0);
  assign is_f0 = (rx_byte == KBD_F0);

  always_ff @(posedge clk) begin
    if (!rst_n) dstate <= DEC_NORMAL;
    else        dstate <= dnext;
  end

  // A prefix in an illegal position restarts the prefix with that byte.
  always_comb begin
    dnext = dstate;
    if (byte_valid) begin
      unique case (1'b1)
        is_e0:   dnext = DEC_GOT_E0;
        is_f0:   dnext = (dstate == DEC_GOT_E0) ? DEC_GOT_E0F0
                                                : DEC_GOT_F0;
        default: dnext = DEC_NORMAL;
      endcase
    end
  end

  always_comb begin
    emit = byte_valid && !is_e0 && !is_f0;
    ext  = (dstate == DEC_GOT_E0) || (dstate == DEC_GOT_E0F0);
    brk  = (dstate == DEC_GOT_F0) || (dstate == DEC_GOT_E0F0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_v <= 1'b0;
      rec_q <= '0;
    end else begin
      rec_v <= emit && ((BREAK_MODE != 0) || !brk);
      rec_q <= '{ext: ext, brk: brk, code: rx_byte};
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, rd, wr, ovf;
  logic [9:0]    head;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign rd    = kbd2pico_rden && !empty;
  assign wr    = rec_v && (!full || rd);
  assign ovf   = rec_v && full && !rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= rec_q;
  end

  assign head           = empty ? '0 : mem[rd_ptr];
  assign kbd2pico_count = count;
  assign kbd2pico_data  = head[7:0];
  assign kbd2pico_flags = head[9:8];

  logic [1:0] err_set;

  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = ovf;
    err_set[ERR_FRM] = frame_err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) kbd_err <= '0;
    else        kbd_err <= err_set | (kbd_err & {2{~err_clr}});
  end

endmodule

// File: tb/tb_kbd_scanq.sv
// Directed bench for kbd_scanq: two instances share the PS/2 pins,
// one make-only with a 4-deep FIFO, one keeping breaks, 8 deep.
module tb_kbd_scanq;

  localparam int H   = 20;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic kbd_clk = 1'b1;
  logic kbd_data = 1'b1;
  logic rden_a = 1'b0, rden_b = 1'b0;
  logic clr_a = 1'b0, clr_b = 1'b0;

  logic [2:0] cnt_a;
  logic [3:0] cnt_b;
  logic [7:0] data_a, data_b;
  logic [1:0] flg_a, flg_b, err_a, err_b;

  kbd_scanq #(.FIFO_DEPTH(4), .BREAK_MODE(0), .TIMEOUT(TMO)) u_a (
    .clk(clk), .rst_n(rst_n),
    .kbd_clk(kbd_clk), .kbd_data(kbd_data),
    .kbd2pico_rden(rden_a), .kbd2pico_count(cnt_a),
    .kbd2pico_data(data_a), .kbd2pico_flags(flg_a),
    .kbd_err(err_a), .err_clr(clr_a)
  );

  kbd_scanq #(.FIFO_DEPTH(8), .BREAK_MODE(1), .TIMEOUT(TMO)) u_b (
    .clk(clk), .rst_n(rst_n),
    .kbd_clk(kbd_clk), .kbd_data(kbd_data),
    .kbd2pico_rden(rden_b), .kbd2pico_count(cnt_b),
    .kbd2pico_data(data_b), .kbd2pico_flags(flg_b),
    .kbd_err(err_b), .err_clr(clr_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] code, input bit bad_par,
                      input bit bad_stop, input bit pop_lat,
                      input int cnt_b_old);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = code;
    bits[9]   = ~(^code) ^ bad_par;
    bits[10]  = ~bad_stop;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk) kbd_data = bits[i];
      repeat (H) @(negedge clk);
      kbd_clk = 1'b0;
      if (pop_lat && i == 10) begin
        repeat (5) @(posedge clk);
        #1 chk("lat_before", cnt_b, cnt_b_old);
        @(negedge clk) rden_a = 1'b1;
        @(posedge clk);
        #1 chk("lat_after", cnt_b, cnt_b_old + 1);
        @(negedge clk) rden_a = 1'b0;
        repeat (H - 7) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      kbd_clk = 1'b1;
    end
    repeat (H) @(negedge clk);
  endtask

  task automatic partial(input int nbits);
    for (int i = 0; i <= nbits; i++) begin
      @(negedge clk) kbd_data = 1'b0;
      repeat (H) @(negedge clk);
      kbd_clk = 1'b0;
      repeat (H) @(negedge clk);
      kbd_clk = 1'b1;
    end
    kbd_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_a();
    @(negedge clk) rden_a = 1'b1;
    @(negedge clk) rden_a = 1'b0;
  endtask

  task automatic pop_b();
    @(negedge clk) rden_b = 1'b1;
    @(negedge clk) rden_b = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge clk) begin clr_a = 1'b1; clr_b = 1'b1; end
    @(negedge clk) begin clr_a = 1'b0; clr_b = 1'b0; end
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    int         cnt_a;
    int         cnt_b;
    int         err;
  } vec_t;

  vec_t tv[14];
  logic [9:0] head_a[4];
  logic [9:0] head_b[6];

  initial begin
    tv[0]  = '{8'h1C, 1'b0, 1'b0, 1, 1, 0};
    tv[1]  = '{8'hE0, 1'b0, 1'b0, 1, 1, 0};
    tv[2]  = '{8'h74, 1'b0, 1'b0, 2, 2, 0};
    tv[3]  = '{8'h1C, 1'b0, 1'b0, 3, 3, 0};
    tv[4]  = '{8'hF0, 1'b0, 1'b0, 3, 3, 0};
    tv[5]  = '{8'h1C, 1'b0, 1'b0, 3, 4, 0};
    tv[6]  = '{8'hE0, 1'b0, 1'b0, 3, 4, 0};
    tv[7]  = '{8'hF0, 1'b0, 1'b0, 3, 4, 0};
    tv[8]  = '{8'h74, 1'b0, 1'b0, 3, 5, 0};
    tv[9]  = '{8'h1C, 1'b1, 1'b0, 3, 5, 1};
    tv[10] = '{8'h55, 1'b0, 1'b1, 3, 5, 1};
    tv[11] = '{8'hF0, 1'b0, 1'b0, 3, 5, 1};
    tv[12] = '{8'hE0, 1'b0, 1'b0, 3, 5, 1};
    tv[13] = '{8'h74, 1'b0, 1'b0, 4, 6, 1};
    head_a = '{10'h01C, 10'h274, 10'h01C, 10'h274};
    head_b = '{10'h01C, 10'h274, 10'h01C, 10'h11C, 10'h374, 10'h274};

    repeat (3) @(negedge clk);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_flg_a", flg_a, 0);
    chk("rst_err_a", err_a, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      send(tv[i].code, tv[i].bad_par, tv[i].bad_stop, 1'b0, 0);
      chk($sformatf("v%0d_cnt_a", i), cnt_a, tv[i].cnt_a);
      chk($sformatf("v%0d_cnt_b", i), cnt_b, tv[i].cnt_b);
      chk($sformatf("v%0d_err_a", i), err_a, tv[i].err);
      chk($sformatf("v%0d_err_b", i), err_b, tv[i].err);
    end

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop%0d_head_a", i), {flg_a, data_a}, head_a[i]);
      pop_a();
    end
    chk("drain_cnt_a", cnt_a, 0);
    chk("drain_head_a", {flg_a, data_a}, 0);
    pop_a();
    chk("empty_pop_a", cnt_a, 0);

    for (int i = 0; i < 6; i++) begin
      chk($sformatf("pop%0d_head_b", i), {flg_b, data_b}, head_b[i]);
      pop_b();
    end
    chk("drain_cnt_b", cnt_b, 0);
    chk("drain_head_b", {flg_b, data_b}, 0);

    clear_errs();
    chk("clr_err_a", err_a, 0);
    chk("clr_err_b", err_b, 0);

    partial(4);
    repeat (TMO + 50) @(negedge clk);
    chk("tmo_err_a", err_a, 1);
    chk("tmo_cnt_a", cnt_a, 0);
    send(8'h29, 1'b0, 1'b0, 1'b0, 0);
    chk("tmo_next_cnt_a", cnt_a, 1);
    chk("tmo_next_head_a", {flg_a, data_a}, 10'h029);
    pop_a();
    pop_b();
    clear_errs();

    for (int i = 0; i < 5; i++)
      send(8'h15 + 8'(i), 1'b0, 1'b0, 1'b0, 0);
    chk("ovf_cnt_a", cnt_a, 4);
    chk("ovf_err_a", err_a, 2);
    chk("ovf_head_a", {flg_a, data_a}, 10'h015);
    chk("ovf_cnt_b", cnt_b, 5);
    chk("ovf_err_b", err_b, 0);
    clear_errs();
    chk("ovf_clr_a", err_a, 0);

    send(8'h1A, 1'b0, 1'b0, 1'b1, 5);
    chk("fullrw_cnt_a", cnt_a, 4);
    chk("fullrw_err_a", err_a, 0);
    chk("fullrw_head_a", {flg_a, data_a}, 10'h016);
    chk("fullrw_cnt_b", cnt_b, 6);

    partial(3);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_cnt_a", cnt_a, 0);
    chk("mid_rst_data_a", data_a, 0);
    chk("mid_rst_flg_a", flg_a, 0);
    chk("mid_rst_err_a", err_a, 0);
    chk("mid_rst_cnt_b", cnt_b, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h33, 1'b0, 1'b0, 1'b0, 0);
    chk("post_rst_cnt_a", cnt_a, 1);
    chk("post_rst_head_a", {flg_a, data_a}, 10'h033);
    chk("post_rst_err_a", err_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_scanq.md
# kbd_scanq

Parametrised PS/2 keyboard front-end for picoVOS, the successor to the fixed 16-deep make-code reader. It deserialises PS/2 frames with parity, framing and stall checking, and decodes E0/F0 prefixes into flagged key records. Records are buffered in a first-word-fall-through FIFO of configurable depth that the PicoBlaze port logic drains. Break codes are optionally kept, and errors are reported as sticky status bits.

## Interface
- FIFO_DEPTH, 16, record FIFO depth; power of two, at least 2
- BREAK_MODE, 0, 0 = discard break records (legacy make-only stream); 1 = queue break records with brk flag
- TIMEOUT, 100000, clk cycles with no kbd_clk falling edge mid-frame before the frame is aborted (2 ms at 50 MHz)
- CW, derived, $clog2(FIFO_DEPTH)+1, count width

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- kbd_clk  in  1  PS/2 clock pin, asynchronous
- kbd_data  in  1  PS/2 data pin, asynchronous
- kbd2pico_rden  in  1  pop head record; ignored when empty
- kbd2pico_count  out  CW  records held, 0..FIFO_DEPTH
- kbd2pico_data  out  8  head scan code; 0 when empty
- kbd2pico_flags  out  2  head flags {ext, brk}; 0 when empty
- kbd_err  out  2  sticky {overflow, frame_err}
- err_clr  in  1  one-cycle pulse; clears kbd_err

## Operation
- Reset: all outputs 0, FIFO empty, receiver IDLE, decoder NORMAL, timeout counter 0.
- Input conditioning: kbd_clk and kbd_data each pass through a 2-FF synchroniser. A falling edge is the synchronised clock being 1 in the previous cycle and 0 in the current one. Data is sampled in the edge cycle.
- Receiver FSM (IDLE, DATA, PARITY, STOP) runs on falling edges:
  - IDLE: data 0 → DATA. Data 1 → stay in IDLE (spurious edge).
  - DATA: shift in 8 bits LSB first → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: if stop = 1 and odd parity holds, pulse byte_valid for one cycle. Otherwise set frame_err and drop the byte. Either way → IDLE.
- Timeout: the counter runs in any state other than IDLE and resets on each falling edge. When it reaches TIMEOUT, the FSM returns to IDLE, frame_err is set, and the partial byte is dropped. The decoder prefix state is kept.
- Decoder FSM (NORMAL, GOT_E0, GOT_F0, GOT_E0F0):
  - E0 moves to GOT_E0.
  - F0 moves to GOT_F0, or from GOT_E0 to GOT_E0F0.
  - Any other byte emits record {ext, brk, code} and returns to NORMAL.
  - E0 or F0 in a state where it is illegal resets the prefix and re-applies the byte.
  - All other bytes (E1, AA, FA, FE, ...) are plain codes.
- A record with brk = 1 is discarded when BREAK_MODE = 0.
- FIFO: stores 10-bit records. Write happens on a record-emit cycle.
  - Write while full with no same-cycle read: record dropped, overflow set.
  - Full with a same-cycle read: both happen, count unchanged.
  - Empty with rden: read ignored; a same-cycle write still lands.
  - Pointers wrap modulo FIFO_DEPTH.
- kbd_err: if set and err_clr occur in the same cycle, set wins.

## Timing
- Latency: the stop bit is sampled low on kbd_clk at the pin at rising edge N. The record is visible and count incremented at rising edge N+5 (sync 2, edge 1, byte_valid 1, decode/write 1).
- FWFT: head data and flags change the cycle after a pop or after a write into an empty FIFO.
- err_clr takes effect the next cycle.
- Reset mid-frame discards the partial byte and all queued records.

## Structure
- Package kbd_pkg holds:
  - prefix constants KBD_E0 = 8'hE0 and KBD_F0 = 8'hF0
  - receiver and decoder state enums
  - flag bit indices FLG_EXT = 1 and FLG_BRK = 0
  - error bit indices ERR_OVF = 1 and ERR_FRM = 0
- Sub-module kbd_ps2_rx contains the synchronisers, receiver FSM and timeout, and outputs byte and byte_valid.
- Decoder, FIFO and status logic are written inline in kbd_scanq.

## Test plan
- Frame 0x1C with correct parity, then E0 74 → two records: {00, 1C} and {10, 74}; count 2. Pop twice → count 0, data 0.
- BREAK_MODE = 0 with stream 1C F0 1C → one record, 1C. BREAK_MODE = 1 with the same stream → records 1C and {01, 1C}.
- Frame 0x1C with bad parity, then frame with stop bit 0 → no record, kbd_err = 01. Pulse err_clr → 00.
- Kill kbd_clk after 4 data bits, wait TIMEOUT+1 cycles, then send valid 0x29 → frame_err set; record 29 queued.
- FIFO_DEPTH = 4: write 5 make codes with no reads → count 4, overflow set, head is the first code. On a full FIFO, a pop in the same cycle as a record write → count stays 4.
- Assert rst_n low mid-frame with 3 records queued → next cycle count 0 and all outputs 0. The next full frame decodes correctly.
